// File: rtl/wb_pkg.sv
// Shared encodings for the writeback unit: writeback-source select, load funct3, FSM states.
package wb_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_MEM  = 2'b01;
  localparam logic [1:0] WB_SEL_LINK = 2'b10;
  localparam logic [1:0] WB_SEL_IMM  = 2'b11;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wb_load_align.sv
// Combinational load-data extraction: selects the byte/half lane from an aligned
// memory word and sign- or zero-extends it to XLEN.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = '0;
    case (addr_lo)
      2'd0: byte_lane = rdata[7:0];
      2'd1: byte_lane = rdata[15:8];
      2'd2: byte_lane = rdata[23:16];
      2'd3: byte_lane = rdata[31:24];
      default: byte_lane = '0;
    endcase
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data = rdata;
    case (funct3)
      LD_B:  data = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      LD_H:  data = {{(XLEN-16){half_lane[15]}}, half_lane};
      LD_BU: data = {{(XLEN-8){1'b0}}, byte_lane};
      LD_HU: data = {{(XLEN-16){1'b0}}, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_writeback_unit.sv
// Writeback unit: forms the register-file write port from ALU/IMM/LINK values or
// aligned load data. Optional forwarding outputs under `WB_BYPASS_EN.
module wb_writeback_unit
  import wb_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [1:0]        in_wb_sel,
  input  logic [XLEN-1:0]   in_alu_res,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [2:0]        in_funct3,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
`ifdef WB_BYPASS_EN
  output logic              byp_valid,
  output logic [REG_AW-1:0] byp_rd,
  output logic [XLEN-1:0]   byp_data,
`endif
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata
);

  wb_state_t         state, state_n;
  logic              accept;
  logic [REG_AW-1:0] ld_rd;
  logic [2:0]        ld_funct3;
  logic [1:0]        ld_addr_lo;
  logic [XLEN-1:0]   ld_data;
  logic [XLEN-1:0]   pc_next;
  logic              wr_en;
  logic [REG_AW-1:0] wr_addr;
  logic [XLEN-1:0]   wr_data;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready;
  assign pc_next  = in_pc + XLEN'(1);

  wb_load_align #(.XLEN(XLEN)) u_align (
    .rdata   (mem_rdata),
    .funct3  (ld_funct3),
    .addr_lo (ld_addr_lo),
    .data    (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // wr_* is the value presented at the next edge; rd==0 only masks the enable.
  always_comb begin
    state_n = state;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_wb_sel == WB_SEL_MEM) begin
            state_n = WAIT_MEM;
          end else begin
            wr_en   = (in_rd != '0);
            wr_addr = in_rd;
            case (in_wb_sel)
              WB_SEL_IMM:  wr_data = in_imm;
              WB_SEL_LINK: wr_data = {pc_next[XLEN-3:0], 2'b00};
              default:     wr_data = in_alu_res;
            endcase
          end
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid) begin
          state_n = IDLE;
          wr_en   = (ld_rd != '0);
          wr_addr = ld_rd;
          wr_data = ld_data;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_rd      <= '0;
      ld_funct3  <= '0;
      ld_addr_lo <= '0;
    end else if (accept && in_wb_sel == WB_SEL_MEM) begin
      ld_rd      <= in_rd;
      ld_funct3  <= in_funct3;
      ld_addr_lo <= in_alu_res[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= wr_en;
      if (wr_en) begin
        rf_waddr <= wr_addr;
        rf_wdata <= wr_data;
      end
    end
  end

`ifdef WB_BYPASS_EN
  assign byp_valid = wr_en;
  assign byp_rd    = wr_addr;
  assign byp_data  = wr_data;
`endif

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Directed self-checking bench for wb_writeback_unit; define WB_BYPASS_EN to also
// exercise the forwarding outputs.
module tb_wb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_res;
  logic [31:0] in_imm;
  logic [31:0] in_pc;
  logic [2:0]  in_funct3;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
`ifdef WB_BYPASS_EN
  logic        byp_valid;
  logic [4:0]  byp_rd;
  logic [31:0] byp_data;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_writeback_unit #(.XLEN(32), .REG_AW(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rd      (in_rd),
    .in_wb_sel  (in_wb_sel),
    .in_alu_res (in_alu_res),
    .in_imm     (in_imm),
    .in_pc      (in_pc),
    .in_funct3  (in_funct3),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
`ifdef WB_BYPASS_EN
    .byp_valid  (byp_valid),
    .byp_rd     (byp_rd),
    .byp_data   (byp_data),
`endif
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [2:0] f3);
    in_valid   = 1'b1;
    in_wb_sel  = sel;
    in_rd      = rd;
    in_alu_res = alu;
    in_funct3  = f3;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_wb_sel = '0; in_alu_res = '0;
    in_imm = '0; in_pc = '0; in_funct3 = '0; mem_rvalid = 1'b0; mem_rdata = '0;

    // reset
    tick(); tick();
    check("rst_we", {31'd0, rf_we}, 32'd0);
    check("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    rst = 1'b0;
    check("rst_ready", {31'd0, in_ready}, 32'd1);

    // 1. ALU
    issue(2'b00, 5'd5, 32'h1234_5678, 3'b000);
    tick();
    in_valid = 1'b0;
    check("alu_we", {31'd0, rf_we}, 32'd1);
    check("alu_waddr", {27'd0, rf_waddr}, 32'd5);
    check("alu_wdata", rf_wdata, 32'h1234_5678);
    tick();
    check("idle_we", {31'd0, rf_we}, 32'd0);
    check("hold_wdata", rf_wdata, 32'h1234_5678);

    // 2. LINK / IMM
    issue(2'b10, 5'd1, 32'h0, 3'b000);
    in_pc = 32'h10;
    tick();
    check("link_wdata", rf_wdata, 32'h44);
    issue(2'b11, 5'd2, 32'h0, 3'b000);
    in_imm = 32'hABCD_E000;
    tick();
    in_valid = 1'b0;
    check("imm_wdata", rf_wdata, 32'hABCD_E000);
    check("imm_waddr", {27'd0, rf_waddr}, 32'd2);

    // 3. LB from byte 3
    issue(2'b01, 5'd10, 32'h103, 3'b000);
    tick();
    in_valid = 1'b1;   // held valid must not be accepted while waiting
    in_wb_sel = 2'b00;
    check("lb_ready0", {31'd0, in_ready}, 32'd0);
    check("lb_we0", {31'd0, rf_we}, 32'd0);
    tick();
    check("lb_ready1", {31'd0, in_ready}, 32'd0);
    tick();
    check("lb_ready2", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h80FF_0000;
`ifdef WB_BYPASS_EN
    #1;
    check("byp_ld_valid", {31'd0, byp_valid}, 32'd1);
    check("byp_ld_data", byp_data, 32'hFFFF_FF80);
`endif
    tick();
    mem_rvalid = 1'b0;
    check("lb_we", {31'd0, rf_we}, 32'd1);
    check("lb_waddr", {27'd0, rf_waddr}, 32'd10);
    check("lb_wdata", rf_wdata, 32'hFFFF_FF80);
    check("lb_ready", {31'd0, in_ready}, 32'd1);

    // stray rvalid in IDLE
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    check("stray_we", {31'd0, rf_we}, 32'd0);

    // LHU from upper half
    issue(2'b01, 5'd11, 32'h102, 3'b101);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h80FF_0000;
    tick();
    mem_rvalid = 1'b0;
    check("lhu_we", {31'd0, rf_we}, 32'd1);
    check("lhu_wdata", rf_wdata, 32'h0000_80FF);

    // LH, addr 0, sign-extended lower half
    issue(2'b01, 5'd12, 32'h200, 3'b001);
    tick();
    in_valid = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_9ABC;
    tick();
    mem_rvalid = 1'b0;
    check("lh_wdata", rf_wdata, 32'hFFFF_9ABC);

    // 4. rd == 0 suppressed
    issue(2'b00, 5'd0, 32'h0000_DEAD, 3'b000);
`ifdef WB_BYPASS_EN
    #1;
    check("byp_rd0_valid", {31'd0, byp_valid}, 32'd0);
`endif
    tick();
    in_valid = 1'b0;
    check("rd0_we", {31'd0, rf_we}, 32'd0);
    check("rd0_hold", rf_wdata, 32'hFFFF_9ABC);

    // back-to-back ALU writes
    issue(2'b00, 5'd1, 32'h11, 3'b000);
    tick();
    check("b2b1_we", {31'd0, rf_we}, 32'd1);
    check("b2b1", {rf_waddr, rf_wdata[26:0]}, {5'd1, 27'h11});
    issue(2'b00, 5'd2, 32'h22, 3'b000);
    tick();
    check("b2b2_we", {31'd0, rf_we}, 32'd1);
    check("b2b2", {rf_waddr, rf_wdata[26:0]}, {5'd2, 27'h22});
    issue(2'b00, 5'd3, 32'h33, 3'b000);
    tick();
    in_valid = 1'b0;
    check("b2b3_we", {31'd0, rf_we}, 32'd1);
    check("b2b3", {rf_waddr, rf_wdata[26:0]}, {5'd3, 27'h33});
    tick();
    check("b2b_end_we", {31'd0, rf_we}, 32'd0);

    // 5. reset while waiting for memory
    issue(2'b01, 5'd4, 32'h100, 3'b010);
    tick();
    in_valid = 1'b0;
    check("rstw_ready0", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstw_we0", {31'd0, rf_we}, 32'd0);
    check("rstw_ready", {31'd0, in_ready}, 32'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_rvalid = 1'b0;
    check("rstw_late_we", {31'd0, rf_we}, 32'd0);
    check("rstw_wdata", rf_wdata, 32'd0);

`ifdef WB_BYPASS_EN
    // 6. bypass on accept cycle
    issue(2'b00, 5'd7, 32'd9, 3'b000);
    #1;
    check("byp_valid", {31'd0, byp_valid}, 32'd1);
    check("byp_rd", {27'd0, byp_rd}, 32'd7);
    check("byp_data", byp_data, 32'd9);
    tick();
    in_valid = 1'b0;
    check("byp_wdata", rf_wdata, 32'd9);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
